// File: rtl/mem_wait_ctrl.sv
// Memory timing stage between the CPU memory controller and the ROM/RAM8 arrays.
// Decodes the request, holds the array strobe for a fixed wait count and returns 1-cycle rdy pulses.
module mem_wait_ctrl #(
  parameter int ROM_WAIT    = 1,
  parameter int RAM_RD_WAIT = 2,
  parameter int RAM_WR_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        startRead,
  input  logic        w,
  input  logic [14:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rom_rdata,
  input  logic [31:0] ram_rdata,
  output logic [10:0] rom_addr,
  output logic        rom_rd,
  output logic [11:0] ram_addr,
  output logic        ram_rd,
  output logic        ram_we,
  output logic [31:0] ram_wdata,
  output logic [31:0] rdata,
  output logic        readrdy,
  output logic        saverdy,
  output logic        busy,
  output logic [2:0]  err,
  input  logic        err_clr
);

  localparam int MAX_RAM  = (RAM_RD_WAIT > RAM_WR_WAIT) ? RAM_RD_WAIT : RAM_WR_WAIT;
  localparam int MAX_WAIT = (ROM_WAIT > MAX_RAM) ? ROM_WAIT : MAX_RAM;
  localparam int CW       = $clog2(MAX_WAIT) + 1;

  localparam logic [CW-1:0] ROM_LD    = CW'(ROM_WAIT - 1);
  localparam logic [CW-1:0] RAM_RD_LD = CW'(RAM_RD_WAIT - 1);
  localparam logic [CW-1:0] RAM_WR_LD = CW'(RAM_WR_WAIT - 1);

  // IDLE: waiting | ROM_RD/RAM_RD/RAM_WR: strobe held, counting down | DONE: rdy pulse
  typedef enum logic [2:0] {IDLE, ROM_RD, RAM_RD, RAM_WR, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          is_rd;
  logic          rom_wr;
  logic          req, rom_sel, bank_sel, accept, cnt_zero;
  logic [2:0]    err_set;
  logic          unused_addr;

  assign unused_addr = ^addr[14:13];

  always_comb begin
    req      = startRead | w;
    rom_sel  = (addr[12:11] == 2'b00);
    bank_sel = (addr[12:11] == 2'b10);
    accept   = (state == IDLE) && req;
    cnt_zero = (cnt == '0);
    err_set  = {accept & w & rom_sel, accept & w & startRead, (state != IDLE) & req};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // ROM writes reuse the write slot timing; ram_we stays low for them
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (w)              state_nxt = RAM_WR;
        else if (startRead) state_nxt = rom_sel ? ROM_RD : RAM_RD;
      end
      ROM_RD, RAM_RD, RAM_WR: if (cnt_zero) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      is_rd     <= 1'b0;
      rom_wr    <= 1'b0;
      rom_addr  <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rdata     <= '0;
      err       <= '0;
    end else begin
      if (accept) begin
        is_rd  <= ~w;
        rom_wr <= w & rom_sel;
        if (w)            cnt <= RAM_WR_LD;
        else if (rom_sel) cnt <= ROM_LD;
        else              cnt <= RAM_RD_LD;
        if (rom_sel && !w) rom_addr  <= addr[10:0];
        if (!rom_sel)      ram_addr  <= {bank_sel, addr[10:0]};
        if (!rom_sel && w) ram_wdata <= wdata;
      end else if ((state == ROM_RD || state == RAM_RD || state == RAM_WR) && !cnt_zero) begin
        cnt <= cnt - 1'b1;
      end
      if (state == ROM_RD && cnt_zero) rdata <= rom_rdata;
      if (state == RAM_RD && cnt_zero) rdata <= ram_rdata;
      err <= (err & ~{3{err_clr}}) | err_set;
    end
  end

  always_comb begin
    rom_rd  = (state == ROM_RD);
    ram_rd  = (state == RAM_RD);
    ram_we  = (state == RAM_WR) && !rom_wr;
    readrdy = (state == DONE) && is_rd;
    saverdy = (state == DONE) && !is_rd;
    busy    = (state != IDLE);
  end

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Bench for mem_wait_ctrl: transaction-level model checked every cycle, plus directed literal checks.
module tb_mem_wait_ctrl;
  localparam int ROM_WAIT    = 1;
  localparam int RAM_RD_WAIT = 2;
  localparam int RAM_WR_WAIT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        startRead = 1'b0, w = 1'b0, err_clr = 1'b0;
  logic [14:0] addr = '0;
  logic [31:0] wdata = '0, rom_rdata = '0, ram_rdata = '0;
  logic [10:0] rom_addr;
  logic [11:0] ram_addr;
  logic        rom_rd, ram_rd, ram_we, readrdy, saverdy, busy;
  logic [31:0] ram_wdata, rdata;
  logic [2:0]  err;

  int n_checks = 0;
  int n_pass   = 0;

  mem_wait_ctrl #(.ROM_WAIT(ROM_WAIT), .RAM_RD_WAIT(RAM_RD_WAIT), .RAM_WR_WAIT(RAM_WR_WAIT)) dut (
    .clk(clk), .rst(rst), .startRead(startRead), .w(w), .addr(addr), .wdata(wdata),
    .rom_rdata(rom_rdata), .ram_rdata(ram_rdata), .rom_addr(rom_addr), .rom_rd(rom_rd),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .rdata(rdata), .readrdy(readrdy), .saverdy(saverdy), .busy(busy), .err(err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Transaction model: rem counts cycles the current request still occupies
  // (WAIT strobe cycles followed by one rdy cycle).
  int          rem = 0;
  bit          m_rd = 0, m_romsel = 0;
  logic [10:0] m_a = '0;
  bit          m_bank = 0;
  logic [31:0] m_wd = '0, m_rdata = '0;
  logic [2:0]  m_err = '0;

  always @(posedge clk or negedge rst) begin
    logic [2:0] e_set;
    if (!rst) begin
      rem = 0; m_rd = 0; m_romsel = 0; m_rdata = '0; m_err = '0;
    end else begin
      e_set = '0;
      if (rem > 0) begin
        if (startRead || w) e_set[0] = 1'b1;
        if (rem == 2 && m_rd) m_rdata = m_romsel ? rom_rdata : ram_rdata;
        rem--;
      end else if (startRead || w) begin
        m_rd     = !w;
        m_romsel = (addr[12:11] == 2'b00);
        m_bank   = (addr[12:11] == 2'b10);
        m_a      = addr[10:0];
        m_wd     = wdata;
        if (w && startRead) e_set[1] = 1'b1;
        if (w && m_romsel)  e_set[2] = 1'b1;
        rem = (w ? RAM_WR_WAIT : (m_romsel ? ROM_WAIT : RAM_RD_WAIT)) + 1;
      end
      m_err = (m_err & ~{3{err_clr}}) | e_set;
    end
  end

  always @(negedge clk) begin
    bit strobe, rdy;
    strobe = rem > 1;
    rdy    = rem == 1;
    check("rom_rd",  32'(rom_rd),  32'(strobe && m_rd && m_romsel));
    check("ram_rd",  32'(ram_rd),  32'(strobe && m_rd && !m_romsel));
    check("ram_we",  32'(ram_we),  32'(strobe && !m_rd && !m_romsel));
    check("readrdy", 32'(readrdy), 32'(rdy && m_rd));
    check("saverdy", 32'(saverdy), 32'(rdy && !m_rd));
    check("busy",    32'(busy),    32'(rem > 0));
    check("rdata",   rdata,        m_rdata);
    check("err",     32'(err),     32'(m_err));
    if (strobe && m_rd && m_romsel) check("rom_addr", 32'(rom_addr), 32'(m_a));
    if (strobe && !m_romsel) check("ram_addr", 32'(ram_addr), 32'({m_bank, m_a}));
    if (strobe && !m_rd && !m_romsel) check("ram_wdata", ram_wdata, m_wd);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #3;
    check("rst_rom_addr", 32'(rom_addr), 32'h0);
    check("rst_ram_addr", 32'(ram_addr), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // 1. ROM read
    rom_rdata = 32'hDEADBEEF; addr = 15'h0005; startRead = 1'b1;
    tick(); startRead = 1'b0;
    check("t1_rom_rd", 32'(rom_rd), 32'h1);
    check("t1_rom_addr", 32'(rom_addr), 32'h005);
    tick();
    check("t1_readrdy", 32'(readrdy), 32'h1);
    check("t1_rdata", rdata, 32'hDEADBEEF);
    tick();
    check("t1_idle", 32'(busy), 32'h0);

    // 2. RAM bank 1 read
    ram_rdata = 32'hCAFEF00D; addr = 15'h1003; startRead = 1'b1;
    tick(); startRead = 1'b0;
    check("t2_ram_rd_a", 32'(ram_rd), 32'h1);
    check("t2_ram_addr", 32'(ram_addr), 32'h803);
    tick();
    check("t2_ram_rd_b", 32'(ram_rd), 32'h1);
    check("t2_no_rdy", 32'(readrdy), 32'h0);
    tick();
    check("t2_readrdy", 32'(readrdy), 32'h1);
    check("t2_rdata", rdata, 32'hCAFEF00D);
    tick();

    // 3. RAM write
    addr = 15'h0842; wdata = 32'h12345678; w = 1'b1;
    tick(); w = 1'b0;
    check("t3_ram_we", 32'(ram_we), 32'h1);
    check("t3_ram_addr", 32'(ram_addr), 32'h042);
    check("t3_ram_wdata", ram_wdata, 32'h12345678);
    tick();
    check("t3_saverdy", 32'(saverdy), 32'h1);
    check("t3_rdata_kept", rdata, 32'hCAFEF00D);
    tick();

    // 4. Collision, then request while busy, then clear
    addr = 15'h1100; wdata = 32'hA5A5A5A5; w = 1'b1; startRead = 1'b1;
    tick(); w = 1'b0;
    check("t4_ram_we", 32'(ram_we), 32'h1);
    check("t4_ram_addr", 32'(ram_addr), 32'h900);
    tick(); startRead = 1'b0;
    check("t4_saverdy", 32'(saverdy), 32'h1);
    check("t4_err", 32'(err), 32'h3);
    tick();
    check("t4_single_rdy", 32'(saverdy), 32'h0);
    err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    check("t4_err_clr", 32'(err), 32'h0);

    // 5. Write to ROM space; busy request with err_clr in the same cycle
    addr = 15'h0010; wdata = 32'h55555555; w = 1'b1;
    tick(); w = 1'b0;
    check("t5_busy", 32'(busy), 32'h1);
    check("t5_no_we", 32'(ram_we), 32'h0);
    check("t5_err", 32'(err), 32'h4);
    startRead = 1'b1; err_clr = 1'b1;
    tick(); startRead = 1'b0; err_clr = 1'b0;
    check("t5_saverdy", 32'(saverdy), 32'h1);
    check("t5_set_wins", 32'(err), 32'h1);
    tick();
    err_clr = 1'b1;
    tick(); err_clr = 1'b0;

    // 6. Reset in the middle of a RAM read
    ram_rdata = 32'h11112222; addr = 15'h1003; startRead = 1'b1;
    tick(); startRead = 1'b0;
    check("t6_ram_rd", 32'(ram_rd), 32'h1);
    #1 rst = 1'b0;
    #1;
    check("t6_rst_ram_rd", 32'(ram_rd), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_ram_addr", 32'(ram_addr), 32'h0);
    check("t6_rst_rom_addr", 32'(rom_addr), 32'h0);
    check("t6_rst_rdata", rdata, 32'h0);
    tick();
    check("t6_no_readrdy", 32'(readrdy), 32'h0);
    tick();
    rst = 1'b1;
    tick();
    rom_rdata = 32'h0BADCAFE; addr = 15'h07FF; startRead = 1'b1;
    tick(); startRead = 1'b0;
    check("t6_rom_addr", 32'(rom_addr), 32'h7FF);
    tick();
    check("t6_readrdy", 32'(readrdy), 32'h1);
    check("t6_rdata", rdata, 32'h0BADCAFE);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
